// File: rtl/axi_brom_pkg.sv
// Shared types and constants for the AXI boot-ROM front-end.
// Holds response/burst encodings, the FSM state types and the beat-step helper.
package axi_brom_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] FIXED = 2'd0;
    localparam logic [1:0] INCR  = 2'd1;
    localparam logic [1:0] WRAP  = 2'd2;

    localparam int ROM_LINE_BYTES = 16;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    // Byte increment between beats for a given AxSIZE.
    function automatic logic [15:0] beat_step(input logic [2:0] size);
        return 16'd1 << size;
    endfunction

endpackage

// File: rtl/axi_brom_wr_sink.sv
// Write-channel terminator: accepts AW and all W beats, answers every burst with SLVERR.
// Burst length comes from wlast alone; the write data is discarded.
module axi_brom_wr_sink
    import axi_brom_pkg::*;
#(
    parameter int ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic                awvalid,
    output logic                awready,
    input  logic                wvalid,
    input  logic                wlast,
    output logic                wready,
    output logic [ID_WIDTH-1:0] bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    wr_state_t           state_r;
    wr_state_t           state_next_s;
    logic [ID_WIDTH-1:0] id_r;
    logic                awready_r;
    logic                wready_r;
    logic                bvalid_r;

    // Next-state decode of the write terminator.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            W_IDLE: begin
                if (awvalid && awready_r) state_next_s = W_DATA;
                else                      state_next_s = W_IDLE;
            end
            W_DATA: begin
                if (wvalid && wready_r && wlast) state_next_s = W_RESP;
                else                             state_next_s = W_DATA;
            end
            W_RESP: begin
                if (bready && bvalid_r) state_next_s = W_IDLE;
                else                    state_next_s = W_RESP;
            end
            default: state_next_s = W_IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            id_r      <= '0;
        end else begin
            state_r   <= state_next_s;
            awready_r <= (state_next_s == W_IDLE);
            wready_r  <= (state_next_s == W_DATA);
            bvalid_r  <= (state_next_s == W_RESP);
            if (awvalid && awready_r) id_r <= awid;
        end
    end

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bid     = id_r;
    assign bresp   = RESP_SLVERR;

endmodule

// File: rtl/axi_brom_ctrl.sv
// AXI4 slave front-end for the 64 KB boot ROM: read bursts become one ROM line
// access per beat; writes are terminated with SLVERR by axi_brom_wr_sink.
module axi_brom_ctrl
    import axi_brom_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 128
) (
    input  logic                      clka,
    input  logic                      rsta_n,
    input  logic [ID_WIDTH-1:0]       s_arid,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic [7:0]                s_arlen,
    input  logic [2:0]                s_arsize,
    input  logic [1:0]                s_arburst,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [ID_WIDTH-1:0]       s_rid,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rlast,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    input  logic [ID_WIDTH-1:0]       s_awid,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic [7:0]                s_awlen,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [ROM_LINE_BYTES-1:0] s_wstrb,
    input  logic                      s_wlast,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [ID_WIDTH-1:0]       s_bid,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [ADDR_WIDTH-1:0]     rom_addra,
    output logic                      rom_ena,
    input  logic [DATA_WIDTH-1:0]     rom_douta,
    output logic [DATA_WIDTH-1:0]     rom_dina,
    output logic [ROM_LINE_BYTES-1:0] rom_wea
);

    rd_state_t           rd_state_r;
    rd_state_t           rd_state_next_s;
    logic                arready_r;
    logic [ID_WIDTH-1:0] id_r;
    logic [15:0]         addr_r;
    logic [15:0]         addr_next_s;
    logic [7:0]          len_r;
    logic [2:0]          size_r;
    logic [1:0]          burst_r;
    logic [8:0]          issued_r;
    logic [8:0]          done_r;
    logic                pend_r;
    logic                ar_hs_s;
    logic                r_hs_s;
    logic                last_beat_s;
    logic                ena_s;
    logic                unused_inputs_s;

    assign ar_hs_s     = s_arvalid && arready_r;
    assign r_hs_s      = pend_r && s_rready;
    assign last_beat_s = pend_r && (done_r == {1'b0, len_r});
    // A new line is fetched only when the output slot is free or being drained,
    // so rom_douta (and with it rdata) holds still during an R stall.
    assign ena_s       = (rd_state_r == R_BURST) && (issued_r <= {1'b0, len_r}) &&
                         (!pend_r || s_rready);

    // Read FSM next-state decode.
    always_comb begin
        rd_state_next_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_hs_s) rd_state_next_s = R_BURST;
                else         rd_state_next_s = R_IDLE;
            end
            R_BURST: begin
                if (last_beat_s && s_rready) rd_state_next_s = R_IDLE;
                else                         rd_state_next_s = R_BURST;
            end
            default: rd_state_next_s = R_IDLE;
        endcase
    end

    // Next beat address; WRAP and reserved encodings walk like INCR.
    always_comb begin
        addr_next_s = addr_r;
        case (burst_r)
            FIXED:      addr_next_s = addr_r;
            INCR, WRAP: addr_next_s = addr_r + beat_step(size_r);
            default:    addr_next_s = addr_r + beat_step(size_r);
        endcase
    end

    // Read-path registers: burst context, beat counters and the pending-beat flag.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b0;
            id_r       <= '0;
            addr_r     <= 16'd0;
            len_r      <= 8'd0;
            size_r     <= 3'd0;
            burst_r    <= 2'd0;
            issued_r   <= 9'd0;
            done_r     <= 9'd0;
            pend_r     <= 1'b0;
        end else begin
            rd_state_r <= rd_state_next_s;
            arready_r  <= (rd_state_next_s == R_IDLE);
            if (ar_hs_s) begin
                id_r     <= s_arid;
                addr_r   <= s_araddr[15:0];
                len_r    <= s_arlen;
                size_r   <= s_arsize;
                burst_r  <= s_arburst;
                issued_r <= 9'd0;
                done_r   <= 9'd0;
            end else begin
                if (ena_s) begin
                    addr_r   <= addr_next_s;
                    issued_r <= issued_r + 9'd1;
                end
                if (r_hs_s) done_r <= done_r + 9'd1;
            end
            if (ena_s)       pend_r <= 1'b1;
            else if (r_hs_s) pend_r <= 1'b0;
            else             pend_r <= pend_r;
        end
    end

    assign s_arready = arready_r;
    assign s_rvalid  = pend_r;
    assign s_rdata   = rom_douta;
    assign s_rresp   = RESP_OKAY;
    assign s_rlast   = last_beat_s;
    assign s_rid     = id_r;

    // Bits above 15 are dropped so the ROM aliases every 64 KB.
    assign rom_ena   = ena_s;
    assign rom_addra = ADDR_WIDTH'(addr_r);
    assign rom_dina  = '0;
    assign rom_wea   = '0;

    assign unused_inputs_s = ^{s_araddr[ADDR_WIDTH-1:16], s_awaddr, s_awlen, s_wdata, s_wstrb};

    axi_brom_wr_sink #(
        .ID_WIDTH(ID_WIDTH)
    ) u_wr_sink (
        .clk     (clka),
        .rst_n   (rsta_n),
        .awid    (s_awid),
        .awvalid (s_awvalid),
        .awready (s_awready),
        .wvalid  (s_wvalid),
        .wlast   (s_wlast),
        .wready  (s_wready),
        .bid     (s_bid),
        .bresp   (s_bresp),
        .bvalid  (s_bvalid),
        .bready  (s_bready)
    );

endmodule

// File: tb/tb_axi_brom_ctrl.sv
// Randomized self-checking bench for axi_brom_ctrl with a behavioural ROM and
// a queue-based reference model of read bursts and write termination.
module tb_axi_brom_ctrl;

    logic         clka = 1'b0;
    logic         rsta_n;
    logic [3:0]   s_arid;
    logic [19:0]  s_araddr;
    logic [7:0]   s_arlen;
    logic [2:0]   s_arsize;
    logic [1:0]   s_arburst;
    logic         s_arvalid, s_arready;
    logic [3:0]   s_rid;
    logic [127:0] s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rlast, s_rvalid, s_rready;
    logic [3:0]   s_awid;
    logic [19:0]  s_awaddr;
    logic [7:0]   s_awlen;
    logic         s_awvalid, s_awready;
    logic [127:0] s_wdata;
    logic [15:0]  s_wstrb;
    logic         s_wlast, s_wvalid, s_wready;
    logic [3:0]   s_bid;
    logic [1:0]   s_bresp;
    logic         s_bvalid, s_bready;
    logic [19:0]  rom_addra;
    logic         rom_ena;
    logic [127:0] rom_douta;
    logic [127:0] rom_dina;
    logic [15:0]  rom_wea;

    axi_brom_ctrl #(.ID_WIDTH(4), .ADDR_WIDTH(20), .DATA_WIDTH(128)) dut (
        .clka(clka), .rsta_n(rsta_n),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid),
        .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .rom_addra(rom_addra), .rom_ena(rom_ena), .rom_douta(rom_douta),
        .rom_dina(rom_dina), .rom_wea(rom_wea)
    );

    always #5 clka = ~clka;

    typedef struct packed {
        logic [3:0]   id;
        logic [127:0] data;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    logic [19:0]  addr_q[$];
    int           n_chk = 0, n_pass = 0, cyc = 0;
    bit           mon_en = 0, rd_busy = 0, first_pending = 0, busy_now;
    int           w_phase = 0, rr_mode = 0;
    logic [3:0]   w_id, last_bid;
    int           ar_cycle = 0, last_cycle = 0, beats_done = 0, base;
    logic [127:0] last_data;
    logic [15:0]  m_a;

    // ROM contents: each 16-bit lane holds 0xA followed by the 12-bit line index.
    function automatic logic [127:0] line_data(input logic [11:0] idx);
        logic [15:0] w;
        w = {4'hA, idx};
        return {8{w}};
    endfunction

    always @(posedge clka) if (rom_ena) rom_douta <= line_data(rom_addra[15:4]);
    always @(posedge clka) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model and compare, sampled on the falling edge.
    initial forever begin
        @(negedge clka);
        if (mon_en) begin
            busy_now = rd_busy;
            chk("arready", s_arready, !busy_now);
            if (s_rvalid && !s_rready) chk("ena_in_stall", rom_ena, 1'b0);
            if (addr_q.size() == 0) chk("rom_ena_idle", rom_ena, 1'b0);
            else if (rom_ena) chk("rom_addra", rom_addra, addr_q.pop_front());
            if (exp_q.size() == 0) chk("rvalid_idle", s_rvalid, 1'b0);
            else if (s_rvalid) begin
                if (first_pending) begin
                    chk("first_latency", cyc - ar_cycle, 2);
                    first_pending = 0;
                end
                chk("rdata", s_rdata, exp_q[0].data);
                chk("rid", s_rid, exp_q[0].id);
                chk("rlast", s_rlast, exp_q[0].last);
                chk("rresp", s_rresp, 2'b00);
                if (s_rready) begin
                    last_data = s_rdata;
                    last_cycle = cyc;
                    beats_done++;
                    if (exp_q[0].last) rd_busy = 0;
                    void'(exp_q.pop_front());
                end
            end
            if (s_arvalid && !busy_now) begin
                for (int i = 0; i <= int'(s_arlen); i++) begin
                    m_a = (s_arburst == 2'd0) ? s_araddr[15:0]
                          : 16'(int'(s_araddr[15:0]) + i * (1 << s_arsize));
                    addr_q.push_back({4'h0, m_a});
                    exp_q.push_back('{id: s_arid, data: line_data(m_a[15:4]),
                                      last: (i == int'(s_arlen))});
                end
                rd_busy = 1; ar_cycle = cyc; first_pending = 1;
            end
            chk("awready", s_awready, w_phase == 0);
            chk("wready", s_wready, w_phase == 1);
            chk("bvalid", s_bvalid, w_phase == 2);
            if (w_phase == 2) begin
                chk("bid", s_bid, w_id);
                chk("bresp", s_bresp, 2'b10);
            end
            case (w_phase)
                0: if (s_awvalid) begin w_id = s_awid; w_phase = 1; end
                1: if (s_wvalid && s_wlast) w_phase = 2;
                default: if (s_bready) begin last_bid = s_bid; w_phase = 0; end
            endcase
        end
    end

    // R-channel backpressure: 0 = always ready, 1 = toggle, 2 = random.
    initial begin
        s_rready = 1'b0;
        forever begin
            @(posedge clka); #1;
            case (rr_mode)
                0: s_rready = 1'b1;
                1: s_rready = ~s_rready;
                default: s_rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic bit rdy(input int sel);
        case (sel)
            0: return s_arready;
            1: return s_awready;
            2: return s_wready;
            default: return s_bvalid;
        endcase
    endfunction

    task automatic wait_hs(input int sel, input string nm);
        int n = 0;
        @(negedge clka);
        while (!rdy(sel) && n < 200) begin n++; @(negedge clka); end
        if (n >= 200) chk({nm, "_timeout"}, rdy(sel), 1'b1);
        @(posedge clka); #1;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [19:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
        s_arid = id; s_araddr = a; s_arlen = len; s_arsize = sz; s_arburst = bu;
        s_arvalid = 1'b1;
        wait_hs(0, "ar");
        s_arvalid = 1'b0;
    endtask

    task automatic wait_rd_idle();
        int n = 0;
        while ((exp_q.size() != 0 || rd_busy) && n < 3000) begin @(posedge clka); #1; n++; end
        if (n >= 3000) chk("rd_idle_timeout", exp_q.size(), 0);
    endtask

    task automatic do_write(input logic [3:0] id, input int nb);
        s_awid = id; s_awaddr = 20'($urandom); s_awlen = 8'(nb - 1); s_awvalid = 1'b1;
        wait_hs(1, "aw");
        s_awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            s_wdata = {4{$urandom}}; s_wstrb = 16'hFFFF; s_wlast = (i == nb - 1);
            s_wvalid = 1'b1;
            wait_hs(2, "w");
            s_wvalid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clka); #1; end
        end
        s_wlast = 1'b0;
        s_bready = 1'b1;
        wait_hs(3, "b");
        s_bready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        rsta_n = 1'b0;
        s_arid = 4'h0; s_araddr = 20'h0; s_arlen = 8'h0; s_arsize = 3'h0; s_arburst = 2'h0;
        s_arvalid = 1'b0; s_awid = 4'h0; s_awaddr = 20'h0; s_awlen = 8'h0; s_awvalid = 1'b0;
        s_wdata = 128'h0; s_wstrb = 16'h0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        chk("rst_arready", s_arready, 1'b0);
        chk("rst_rvalid", s_rvalid, 1'b0);
        chk("rst_rlast", s_rlast, 1'b0);
        chk("rst_bvalid", s_bvalid, 1'b0);
        chk("rst_rom_ena", rom_ena, 1'b0);
        chk("rst_rom_addra", rom_addra, 20'h0);
        chk("rst_wready", s_wready, 1'b0);
        chk("rom_dina_tie", rom_dina, 128'h0);
        chk("rom_wea_tie", rom_wea, 16'h0);
        @(negedge clka); #2;
        rsta_n = 1'b1; mon_en = 1;
        @(posedge clka); #1;

        // INCR 0x100 len 3 size 4 with rready held high
        rr_mode = 0;
        do_ar(4'h1, 20'h00100, 8'd3, 3'd4, 2'd1);
        wait_rd_idle();
        chk("t1_last_data", last_data, 128'hA013_A013_A013_A013_A013_A013_A013_A013);
        chk("t1_rlast_cycle", last_cycle - ar_cycle, 5);

        // Same burst with rready toggling every cycle
        rr_mode = 1; base = beats_done;
        do_ar(4'h2, 20'h00100, 8'd3, 3'd4, 2'd1);
        wait_rd_idle();
        chk("t2_beats", beats_done - base, 4);
        chk("t2_last_data", last_data, 128'hA013_A013_A013_A013_A013_A013_A013_A013);

        // FIXED burst at 0x40, three beats of line 4
        rr_mode = 0; base = beats_done;
        do_ar(4'h6, 20'h00040, 8'd2, 3'd4, 2'd0);
        wait_rd_idle();
        chk("t3_beats", beats_done - base, 3);
        chk("t3_last_data", last_data, 128'hA004_A004_A004_A004_A004_A004_A004_A004);

        // Back-to-back ARs: the second is accepted the cycle after the first rlast
        do_ar(4'h3, 20'h00200, 8'd1, 3'd4, 2'd1);
        do_ar(4'h5, 20'h00300, 8'd2, 3'd4, 2'd1);
        chk("t4_ar_gap", ar_cycle - last_cycle, 1);
        wait_rd_idle();
        chk("t4_last_data", last_data, 128'hA032_A032_A032_A032_A032_A032_A032_A032);

        // Write of two beats concurrent with a read burst
        fork
            begin do_ar(4'h9, 20'h01000, 8'd7, 3'd4, 2'd1); wait_rd_idle(); end
            begin do_write(4'h7, 2); end
        join
        chk("t5_bid", last_bid, 4'h7);
        chk("t5_last_data", last_data, 128'hA107_A107_A107_A107_A107_A107_A107_A107);

        // Reset in the middle of a burst, then a fresh burst
        base = beats_done;
        do_ar(4'hA, 20'h02000, 8'd7, 3'd4, 2'd1);
        for (int n = 0; n < 200 && beats_done < base + 2; n++) begin @(posedge clka); #1; end
        chk("t6_beats_before_reset", beats_done >= base + 2, 1'b1);
        @(negedge clka); #2;
        rsta_n = 1'b0; mon_en = 0;
        #1;
        chk("t6_rvalid_drop", s_rvalid, 1'b0);
        chk("t6_arready_rst", s_arready, 1'b0);
        chk("t6_rom_ena_rst", rom_ena, 1'b0);
        exp_q.delete(); addr_q.delete();
        rd_busy = 0; first_pending = 0; w_phase = 0;
        repeat (2) @(posedge clka);
        @(negedge clka); #2;
        rsta_n = 1'b1; mon_en = 1;
        @(posedge clka); #1;
        chk("t6_arready_after", s_arready, 1'b1);
        do_ar(4'hB, 20'h003F0, 8'd1, 3'd4, 2'd1);
        wait_rd_idle();
        chk("t6_last_data", last_data, 128'hA040_A040_A040_A040_A040_A040_A040_A040);

        // Randomized bursts with random backpressure and concurrent writes
        rr_mode = 2;
        repeat (25) begin
            logic [3:0]  rid;
            logic [19:0] ra;
            logic [7:0]  rl;
            logic [2:0]  rs;
            logic [1:0]  rb;
            rid = 4'($urandom); ra = 20'($urandom); rl = 8'($urandom_range(0, 15));
            rs = 3'($urandom_range(0, 4)); rb = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                fork
                    begin do_ar(rid, ra, rl, rs, rb); wait_rd_idle(); end
                    begin do_write(4'($urandom), int'($urandom_range(1, 4))); end
                join
            end else begin
                do_ar(rid, ra, rl, rs, rb);
                wait_rd_idle();
            end
        end

        repeat (3) @(posedge clka);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
